// File: rtl/mcast_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// mcast_scheduler_pkg
// Shared switch definitions for the multicast scheduler: port count, index and
// mask types, the default grant hold limit and a mask overlap helper.
// No ports (package).
// -----------------------------------------------------------------------------
package mcast_scheduler_pkg;

   localparam int NUM_PORTS    = 4;
   localparam int MAX_HOLD_DEF = 64;
   localparam int HOLD_W       = 8;

   typedef logic [1:0]        port_idx_t;
   typedef logic [3:0]        port_mask_t;
   typedef logic [HOLD_W-1:0] hold_cnt_t;

   // True when the two output masks share at least one output.
   function automatic logic mask_overlap(input port_mask_t a, input port_mask_t b);
      mask_overlap = |(a & b);
   endfunction

endpackage

// File: rtl/mcast_scheduler_hold.sv
// -----------------------------------------------------------------------------
// sched_hold_timer
// Per-requester grant hold counter. Restarts when a grant is issued, counts
// every granted cycle and flags expiry in the MAX_HOLD-th granted cycle so the
// owner releases on the following edge.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       a new grant is issued to this requester this cycle
//   active      this requester currently holds a grant
//   rel         this requester's grant is released this cycle
//   expire      combinational: current cycle is the last allowed granted cycle
// -----------------------------------------------------------------------------
module sched_hold_timer
   import mcast_scheduler_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF
)(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic active,
   input  logic rel,
   output logic expire
);

   // Counter value in the last permitted granted cycle (count starts at 0).
   localparam hold_cnt_t LIMIT = hold_cnt_t'(MAX_HOLD - 1);

   hold_cnt_t cnt_r;

   // Granted-cycle counter; cleared on a new grant and after release.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= hold_cnt_t'(0);
      end else if (start || rel) begin
         cnt_r <= hold_cnt_t'(0);
      end else if (active) begin
         cnt_r <= cnt_r + hold_cnt_t'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = active && (cnt_r == LIMIT);

endmodule

// File: rtl/mcast_scheduler.sv
// -----------------------------------------------------------------------------
// mcast_scheduler
// All-or-nothing multicast output allocator. Each cycle eligible requesters are
// scanned round-robin from rr_ptr and granted greedily when every output in
// their mask is free; the head requester's mask is reserved when it is blocked.
// Grants are held until done or until MAX_HOLD granted cycles elapse.
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   req          [N]    requester has a head packet
//   target       [4N]   output mask per requester, [4i+3:4i]
//   done         [N]    transfer finished pulse
//   grant        [N]    requester owns its latched outputs
//   out_busy     [N]    output is owned
//   out_sel      [2N]   owning requester per output, 0 when free
//   timeout_err  [N]    pulse when a grant is force-released
// -----------------------------------------------------------------------------
module mcast_scheduler #(
   parameter int NUM_PORTS = mcast_scheduler_pkg::NUM_PORTS,
   parameter int MAX_HOLD  = mcast_scheduler_pkg::MAX_HOLD_DEF
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_PORTS-1:0]   req,
   input  logic [4*NUM_PORTS-1:0] target,
   input  logic [NUM_PORTS-1:0]   done,
   output logic [NUM_PORTS-1:0]   grant,
   output logic [NUM_PORTS-1:0]   out_busy,
   output logic [2*NUM_PORTS-1:0] out_sel,
   output logic [NUM_PORTS-1:0]   timeout_err
);

   import mcast_scheduler_pkg::*;

   // Registered state
   logic [NUM_PORTS-1:0]   grant_r;
   logic [NUM_PORTS-1:0]   timeout_err_r;
   port_mask_t             out_busy_r;
   logic [2*NUM_PORTS-1:0] out_sel_r;
   port_mask_t             mask_r [NUM_PORTS];
   port_idx_t              rr_ptr_r;

   // Combinational
   port_mask_t             target_s      [NUM_PORTS];
   port_mask_t             mask_next_s   [NUM_PORTS];
   logic [NUM_PORTS-1:0]   eligible_s;
   logic [NUM_PORTS-1:0]   new_grant_s;
   logic [NUM_PORTS-1:0]   release_s;
   logic [NUM_PORTS-1:0]   expire_s;
   logic [NUM_PORTS-1:0]   grant_next_s;
   logic [NUM_PORTS-1:0]   timeout_next_s;
   port_mask_t             busy_next_s;
   logic [2*NUM_PORTS-1:0] sel_next_s;
   port_idx_t              rr_next_s;
   port_mask_t             taken_s;
   port_idx_t              idx_s;

   // Split the flat target bus and qualify eligibility and release per requester.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         target_s[i]   = target[4*i +: 4];
         eligible_s[i] = req[i] && !grant_r[i] && (target_s[i] != 4'b0000);
         release_s[i]  = grant_r[i] && (done[i] || expire_s[i]);
      end
   end

   // Round-robin greedy allocation. taken_s accumulates busy outputs, outputs
   // granted earlier in the scan, and the blocked head requester's reservation.
   // Index arithmetic wraps in port_idx_t, which matches NUM_PORTS = 4.
   always_comb begin
      new_grant_s = '0;
      rr_next_s   = rr_ptr_r;
      taken_s     = out_busy_r;
      idx_s       = rr_ptr_r;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx_s = rr_ptr_r + port_idx_t'(k);
         if (eligible_s[idx_s]) begin
            if (!mask_overlap(target_s[idx_s], taken_s)) begin
               new_grant_s[idx_s] = 1'b1;
               taken_s            = taken_s | target_s[idx_s];
               rr_next_s          = idx_s + 2'd1;
            end else if (k == 0) begin
               taken_s = taken_s | target_s[idx_s];
            end else begin
               taken_s = taken_s;
            end
         end else begin
            taken_s = taken_s;
         end
      end
   end

   // Next grant/mask state and the output views derived from it, so that the
   // registered busy/sel always agree with the registered grants.
   always_comb begin
      grant_next_s   = '0;
      timeout_next_s = '0;
      busy_next_s    = 4'b0000;
      sel_next_s     = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         mask_next_s[i] = mask_r[i];
         if (new_grant_s[i]) begin
            grant_next_s[i] = 1'b1;
            mask_next_s[i]  = target_s[i];
         end else if (release_s[i]) begin
            grant_next_s[i] = 1'b0;
            mask_next_s[i]  = 4'b0000;
         end else begin
            grant_next_s[i] = grant_r[i];
         end
         // A done arriving in the expiry cycle counts as a normal release.
         timeout_next_s[i] = release_s[i] && expire_s[i] && !done[i];
         busy_next_s       = busy_next_s | mask_next_s[i];
      end
      for (int j = 0; j < NUM_PORTS; j++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (mask_next_s[i][j]) begin
               sel_next_s[2*j +: 2] = port_idx_t'(i);
            end else begin
               sel_next_s[2*j +: 2] = sel_next_s[2*j +: 2];
            end
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_r       <= '0;
         timeout_err_r <= '0;
         out_busy_r    <= 4'b0000;
         out_sel_r     <= '0;
         rr_ptr_r      <= 2'd0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            mask_r[i] <= 4'b0000;
         end
      end else begin
         grant_r       <= grant_next_s;
         timeout_err_r <= timeout_next_s;
         out_busy_r    <= busy_next_s;
         out_sel_r     <= sel_next_s;
         rr_ptr_r      <= rr_next_s;
         for (int i = 0; i < NUM_PORTS; i++) begin
            mask_r[i] <= mask_next_s[i];
         end
      end
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timer
      sched_hold_timer #(
         .MAX_HOLD (MAX_HOLD)
      ) u_timer (
         .clk    (clk),
         .rst    (rst),
         .start  (new_grant_s[i]),
         .active (grant_r[i]),
         .rel    (release_s[i]),
         .expire (expire_s[i])
      );
   end

   assign grant       = grant_r;
   assign out_busy    = out_busy_r;
   assign out_sel     = out_sel_r;
   assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mcast_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mcast_scheduler
// Directed stimulus for mcast_scheduler (NUM_PORTS=4, MAX_HOLD=4). Each step
// drives one cycle of inputs and queues the outputs expected after the next
// clock edge; a monitor pops and compares them independently.
// -----------------------------------------------------------------------------
module tb_mcast_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = 4'b0000;
   logic [15:0] target = 16'h0000;
   logic [3:0]  done = 4'b0000;
   logic [3:0]  grant;
   logic [3:0]  out_busy;
   logic [7:0]  out_sel;
   logic [3:0]  timeout_err;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      int         tag;
      string      nm;
      logic [3:0] g;
      logic [3:0] b;
      logic [7:0] s;
      logic [3:0] te;
      int         rr;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   mcast_scheduler #(
      .NUM_PORTS (4),
      .MAX_HOLD  (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .target      (target),
      .done        (done),
      .grant       (grant),
      .out_busy    (out_busy),
      .out_sel     (out_sel),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // Cycle counter used to tag expectations.
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due at this cycle.
   always @(posedge clk) begin
      #2;
      while (sb_q.size() > 0 && sb_q[0].tag <= cyc) begin
         mon_e = sb_q.pop_front();
         n_chk++;
         if (mon_e.tag != cyc ||
             {grant, out_busy, out_sel, timeout_err} !== {mon_e.g, mon_e.b, mon_e.s, mon_e.te}) begin
            n_fail++;
            $display("FAIL %s (cyc %0d): got grant=%b busy=%b sel=%h terr=%b, expected grant=%b busy=%b sel=%h terr=%b",
                     mon_e.nm, cyc, grant, out_busy, out_sel, timeout_err,
                     mon_e.g, mon_e.b, mon_e.s, mon_e.te);
         end
         if (mon_e.rr >= 0) begin
            n_chk++;
            if (dut.rr_ptr_r !== mon_e.rr[1:0]) begin
               n_fail++;
               $display("FAIL %s rr_ptr: got %0d, expected %0d", mon_e.nm, dut.rr_ptr_r, mon_e.rr);
            end
         end
      end
   end

   // Drive one cycle of inputs and queue the outputs expected after the edge.
   task automatic step(input string nm, input logic r_rst, input logic [3:0] r,
                       input logic [15:0] t, input logic [3:0] d,
                       input logic [3:0] eg, input logic [3:0] eb,
                       input logic [7:0] es, input logic [3:0] ete, input int err);
      exp_t e;
      @(negedge clk);
      rst    = r_rst;
      req    = r;
      target = t;
      done   = d;
      e.tag = cyc + 1;
      e.nm  = nm;
      e.g   = eg;
      e.b   = eb;
      e.s   = es;
      e.te  = ete;
      e.rr  = err;
      sb_q.push_back(e);
   endtask

   initial begin
      // Reset state
      step("rst0", 1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0);
      step("rst1", 1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, -1);

      // Two disjoint requesters granted together
      step("a_pair", 1'b0, 4'b0011, 16'h0021, 4'b0000, 4'b0011, 4'b0011, 8'h04, 4'b0000, 2);
      step("a_done", 1'b0, 4'b0000, 16'h0021, 4'b0011, 4'b0000, 4'b0000, 8'h00, 4'b0000, 2);

      // Conflict on output 0, r1 waits for r0's done, granted two cycles later
      step("b_r0",    1'b0, 4'b0001, 16'h0011, 4'b0000, 4'b0001, 4'b0001, 8'h00, 4'b0000, 1);
      step("b_block", 1'b0, 4'b0011, 16'h0011, 4'b0000, 4'b0001, 4'b0001, 8'h00, 4'b0000, 1);
      step("b_done0", 1'b0, 4'b0010, 16'h0011, 4'b0001, 4'b0000, 4'b0000, 8'h00, 4'b0000, -1);
      step("b_r1",    1'b0, 4'b0010, 16'h0011, 4'b0000, 4'b0010, 4'b0001, 8'h01, 4'b0000, 2);
      step("b_done1", 1'b0, 4'b0000, 16'h0011, 4'b0010, 4'b0000, 4'b0000, 8'h00, 4'b0000, 2);

      // Head reservation: r0 wants 1111 while r2 holds output 2; r3 must wait
      step("c_setup",   1'b0, 4'b1100, 16'h1400, 4'b0000, 4'b1100, 4'b0101, 8'h23, 4'b0000, 0);
      step("c_r3done",  1'b0, 4'b0100, 16'h1400, 4'b1000, 4'b0100, 4'b0100, 8'h20, 4'b0000, 0);
      step("c_reserve", 1'b0, 4'b1101, 16'h140F, 4'b0000, 4'b0100, 4'b0100, 8'h20, 4'b0000, 0);
      step("c_done2",   1'b0, 4'b1001, 16'h140F, 4'b0100, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0);
      step("c_wide",    1'b0, 4'b1001, 16'h140F, 4'b0000, 4'b0001, 4'b1111, 8'h00, 4'b0000, 1);
      step("c_done0",   1'b0, 4'b1000, 16'h140F, 4'b0001, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1);
      step("c_r3",      1'b0, 4'b1000, 16'h140F, 4'b0000, 4'b1000, 4'b0001, 8'h03, 4'b0000, 0);
      step("c_done3",   1'b0, 4'b0000, 16'h140F, 4'b1000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0);

      // Timeout: r1 held 4 cycles with no done, timeout_err once
      step("d_grant", 1'b0, 4'b0010, 16'h0020, 4'b0000, 4'b0010, 4'b0010, 8'h04, 4'b0000, 2);
      for (int i = 0; i < 3; i++) begin
         step("d_hold", 1'b0, 4'b0000, 16'h0020, 4'b0000, 4'b0010, 4'b0010, 8'h04, 4'b0000, -1);
      end
      step("d_expire", 1'b0, 4'b0000, 16'h0020, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0010, 2);
      step("d_quiet",  1'b0, 4'b0000, 16'h0020, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, -1);

      // done coinciding with expiry: single release, no timeout_err
      step("e_grant", 1'b0, 4'b0100, 16'h0400, 4'b0000, 4'b0100, 4'b0100, 8'h20, 4'b0000, 3);
      for (int i = 0; i < 3; i++) begin
         step("e_hold", 1'b0, 4'b0000, 16'h0400, 4'b0000, 4'b0100, 4'b0100, 8'h20, 4'b0000, -1);
      end
      step("e_coincide", 1'b0, 4'b0000, 16'h0400, 4'b0100, 4'b0000, 4'b0000, 8'h00, 4'b0000, 3);

      // Reset in the middle of a full-width grant
      step("f_wide", 1'b0, 4'b0001, 16'h000F, 4'b0000, 4'b0001, 4'b1111, 8'h00, 4'b0000, 1);
      step("f_hold", 1'b0, 4'b0001, 16'h000F, 4'b0000, 4'b0001, 4'b1111, 8'h00, 4'b0000, 1);
      step("f_rst",  1'b1, 4'b0001, 16'h000F, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0);

      // Four requesters contend for output 0: grant order 0,1,2,3,0
      step("g_r0a",  1'b0, 4'b1111, 16'h1111, 4'b0000, 4'b0001, 4'b0001, 8'h00, 4'b0000, 1);
      step("g_d0",   1'b0, 4'b1111, 16'h1111, 4'b0001, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1);
      step("g_r1",   1'b0, 4'b1111, 16'h1111, 4'b0000, 4'b0010, 4'b0001, 8'h01, 4'b0000, 2);
      step("g_d1",   1'b0, 4'b1111, 16'h1111, 4'b0010, 4'b0000, 4'b0000, 8'h00, 4'b0000, 2);
      step("g_r2",   1'b0, 4'b1111, 16'h1111, 4'b0000, 4'b0100, 4'b0001, 8'h02, 4'b0000, 3);
      step("g_d2",   1'b0, 4'b1111, 16'h1111, 4'b0100, 4'b0000, 4'b0000, 8'h00, 4'b0000, 3);
      step("g_r3",   1'b0, 4'b1111, 16'h1111, 4'b0000, 4'b1000, 4'b0001, 8'h03, 4'b0000, 0);
      step("g_d3",   1'b0, 4'b1111, 16'h1111, 4'b1000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0);
      step("g_r0b",  1'b0, 4'b1111, 16'h1111, 4'b0000, 4'b0001, 4'b0001, 8'h00, 4'b0000, 1);
      step("g_d0b",  1'b0, 4'b0000, 16'h1111, 4'b0001, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1);

      // Zero mask never granted; done without a grant ignored
      step("z_zeromask", 1'b0, 4'b0001, 16'h0000, 4'b1111, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1);
      step("z_idle",     1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1);

      @(negedge clk);
      req  = 4'b0000;
      done = 4'b0000;

      // Bounded drain of the scoreboard
      for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
         @(negedge clk);
      end
      if (sb_q.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
